// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported memory: port 0 (fetch) and port 1 (data)
// share one access path; each access takes IDLE -> ACCESS -> ACK and completes with a one-cycle ack.
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int FAIR = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_p0_req,
  input  logic [15:0] i_p0_addr,
  input  logic [31:0] i_p0_data,
  input  logic [1:0]  i_p0_size,
  input  logic        i_p0_we,
  input  logic        i_p1_req,
  input  logic [15:0] i_p1_addr,
  input  logic [31:0] i_p1_data,
  input  logic [1:0]  i_p1_size,
  input  logic        i_p1_we,
  output logic        o_p0_ack,
  output logic [31:0] o_p0_data,
  output logic        o_p1_ack,
  output logic [31:0] o_p1_data,
  output logic [15:0] o_m_addr,
  output logic [31:0] o_m_data,
  output logic [1:0]  o_m_size,
  output logic        o_m_we,
  input  logic [31:0] i_m_data,
  output logic [1:0]  o_grant,
  output logic [1:0]  o_state
);

  // Handshake: a requester raises req with addr/data/size/we stable and holds them
  // until its ack pulse; req is only sampled in IDLE, so a req still high after ack is a new request.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  state_e      state_q;
  logic        last_p1_q;
  logic [15:0] m_addr_q;
  logic [31:0] m_data_q;
  logic [1:0]  m_size_q;
  logic        m_we_q;
  logic [1:0]  grant_q;
  logic        p0_ack_q;
  logic        p1_ack_q;
  logic [31:0] p0_data_q;
  logic [31:0] p1_data_q;

  logic any_req;
  logic win_p1;

  // Round-robin hands a tie to the port that did not win last time.
  always_comb begin
    any_req = i_p0_req | i_p1_req;
    win_p1  = 1'b0;
    if (FAIR != 0) begin
      win_p1 = i_p1_req & (~i_p0_req | ~last_p1_q);
    end else begin
      win_p1 = i_p1_req & ~i_p0_req;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      last_p1_q <= 1'b1;
      m_addr_q  <= 16'h0000;
      m_data_q  <= 32'h0000_0000;
      m_size_q  <= 2'b00;
      m_we_q    <= 1'b1;
      grant_q   <= 2'b00;
      p0_ack_q  <= 1'b0;
      p1_ack_q  <= 1'b0;
      p0_data_q <= 32'h0000_0000;
      p1_data_q <= 32'h0000_0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q   <= ACCESS;
            last_p1_q <= win_p1;
            m_addr_q  <= win_p1 ? i_p1_addr : i_p0_addr;
            m_data_q  <= win_p1 ? i_p1_data : i_p0_data;
            m_size_q  <= win_p1 ? i_p1_size : i_p0_size;
            m_we_q    <= win_p1 ? i_p1_we : i_p0_we;
            grant_q   <= win_p1 ? 2'b10 : 2'b01;
          end
        end
        ACCESS: begin
          // The memory commits a write on this same edge; reads are captured here.
          state_q  <= ACK;
          m_we_q   <= 1'b1;
          p0_ack_q <= grant_q[0];
          p1_ack_q <= grant_q[1];
          if (m_we_q) begin
            if (grant_q[1]) begin
              p1_data_q <= i_m_data;
            end else begin
              p0_data_q <= i_m_data;
            end
          end
        end
        ACK: begin
          state_q  <= IDLE;
          p0_ack_q <= 1'b0;
          p1_ack_q <= 1'b0;
          grant_q  <= 2'b00;
        end
        default: begin
          state_q  <= IDLE;
          m_we_q   <= 1'b1;
          p0_ack_q <= 1'b0;
          p1_ack_q <= 1'b0;
          grant_q  <= 2'b00;
        end
      endcase
    end
  end

  assign o_p0_ack  = p0_ack_q;
  assign o_p1_ack  = p1_ack_q;
  assign o_p0_data = p0_data_q;
  assign o_p1_data = p1_data_q;
  assign o_m_addr  = m_addr_q;
  assign o_m_data  = m_data_q;
  assign o_m_size  = m_size_q;
  assign o_m_we    = m_we_q;
  assign o_grant   = grant_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin instance backed by a byte-addressed memory model and
// a fixed-priority instance backed by an address-echo memory, checked through per-port expected queues.
`timescale 1ns/1ps

module tb_mem_arbiter;

  localparam int W = 51;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int compared = 0;
  int mismatched = 0;

  // ---------------- round-robin instance ----------------
  logic        p_req[2];
  logic [15:0] p_addr[2];
  logic [31:0] p_wdata[2];
  logic [1:0]  p_size[2];
  logic        p_we[2];
  logic        a_ack0, a_ack1, a_mwe;
  logic [31:0] a_d0, a_d1, a_mdata, a_mrd;
  logic [15:0] a_maddr;
  logic [1:0]  a_msize, a_grant, a_state;

  mem_arbiter #(.FAIR(1)) dut_rr (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_p0_req(p_req[0]), .i_p0_addr(p_addr[0]), .i_p0_data(p_wdata[0]),
    .i_p0_size(p_size[0]), .i_p0_we(p_we[0]),
    .i_p1_req(p_req[1]), .i_p1_addr(p_addr[1]), .i_p1_data(p_wdata[1]),
    .i_p1_size(p_size[1]), .i_p1_we(p_we[1]),
    .o_p0_ack(a_ack0), .o_p0_data(a_d0), .o_p1_ack(a_ack1), .o_p1_data(a_d1),
    .o_m_addr(a_maddr), .o_m_data(a_mdata), .o_m_size(a_msize), .o_m_we(a_mwe),
    .i_m_data(a_mrd), .o_grant(a_grant), .o_state(a_state)
  );

  // Little-endian byte memory; writes commit on the edge that ends ACCESS.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (rst_n && !a_mwe) begin
      case (a_msize)
        2'b00: mem[a_maddr] <= a_mdata[7:0];
        2'b01, 2'b10: begin
          mem[a_maddr]         <= a_mdata[7:0];
          mem[a_maddr + 16'd1] <= a_mdata[15:8];
        end
        default: begin
          mem[a_maddr]         <= a_mdata[7:0];
          mem[a_maddr + 16'd1] <= a_mdata[15:8];
          mem[a_maddr + 16'd2] <= a_mdata[23:16];
          mem[a_maddr + 16'd3] <= a_mdata[31:24];
        end
      endcase
    end
  end

  always_comb begin
    a_mrd = 32'h0;
    case (a_msize)
      2'b00:        a_mrd = {24'h0, mem[a_maddr]};
      2'b01, 2'b10: a_mrd = {16'h0, mem[a_maddr + 16'd1], mem[a_maddr]};
      default:      a_mrd = {mem[a_maddr + 16'd3], mem[a_maddr + 16'd2],
                             mem[a_maddr + 16'd1], mem[a_maddr]};
    endcase
  end

  // ---------------- fixed-priority instance ----------------
  logic        f_req0, f_req1, f_ack0, f_ack1, f_mwe;
  logic [31:0] f_d0, f_d1, f_mdata, f_mrd;
  logic [15:0] f_maddr;
  logic [1:0]  f_msize, f_grant, f_state;
  assign f_mrd = {16'hF00D, f_maddr};

  mem_arbiter #(.FAIR(0)) dut_fx (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_p0_req(f_req0), .i_p0_addr(16'h0100), .i_p0_data(32'h0),
    .i_p0_size(2'b11), .i_p0_we(1'b1),
    .i_p1_req(f_req1), .i_p1_addr(16'h0200), .i_p1_data(32'h0),
    .i_p1_size(2'b11), .i_p1_we(1'b1),
    .o_p0_ack(f_ack0), .o_p0_data(f_d0), .o_p1_ack(f_ack1), .o_p1_data(f_d1),
    .o_m_addr(f_maddr), .o_m_data(f_mdata), .o_m_size(f_msize), .o_m_we(f_mwe),
    .i_m_data(f_mrd), .o_grant(f_grant), .o_state(f_state)
  );

  // Index: 0 = rr p0, 1 = rr p1, 2 = fixed p0, 3 = fixed p1.
  logic        ack_v[4];
  logic [31:0] dat_v[4];
  logic [1:0]  gnt_v[4];
  assign ack_v[0] = a_ack0;  assign dat_v[0] = a_d0;  assign gnt_v[0] = a_grant;
  assign ack_v[1] = a_ack1;  assign dat_v[1] = a_d1;  assign gnt_v[1] = a_grant;
  assign ack_v[2] = f_ack0;  assign dat_v[2] = f_d0;  assign gnt_v[2] = f_grant;
  assign ack_v[3] = f_ack1;  assign dat_v[3] = f_d1;  assign gnt_v[3] = f_grant;

  // ---------------- scoreboard ----------------
  // Entry: {check_cycle, cycle[15:0], is_read, data_known, data[31:0]}
  logic [W-1:0] exp_q[4][$];

  function automatic logic [W-1:0] mk(bit chk_c, int c, bit rd, bit known, logic [31:0] d);
    return {chk_c, 16'(c), rd, known, d};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  logic [31:0] shadow[4];
  bit          known[4];

  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    int j;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        shadow[i] = 32'h0;
        known[i]  = 1'b1;
      end
    end else begin
      chk("one_ack_rr", a_ack0 & a_ack1, 0);
      chk("one_ack_fx", f_ack0 & f_ack1, 0);
      chk("we_outside_access_rr", (!a_mwe) && (a_state != ST_ACCESS), 0);
      chk("we_outside_access_fx", (!f_mwe) && (f_state != ST_ACCESS), 0);
      for (int i = 0; i < 4; i++) begin
        if (ack_v[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("unexpected_ack_%0d", i), 1, 0);
          end else begin
            e = exp_q[i].pop_front();
            j = i ^ 1;
            if (e[50]) chk($sformatf("ack_cycle_%0d", i), cyc, e[49:34]);
            chk($sformatf("grant_%0d", i), gnt_v[i], (i % 2 == 1) ? 2'b10 : 2'b01);
            if (e[33]) begin
              if (e[32]) begin
                chk($sformatf("read_data_%0d", i), dat_v[i], e[31:0]);
                shadow[i] = e[31:0];
                known[i]  = 1'b1;
              end else begin
                known[i] = 1'b0;
              end
            end else if (known[i]) begin
              chk($sformatf("data_kept_on_write_%0d", i), dat_v[i], shadow[i]);
            end
            if (known[j]) chk($sformatf("data_kept_other_%0d", j), dat_v[j], shadow[j]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst_n = 1'b0;
    p_req[0] = 1'b0;
    p_req[1] = 1'b0;
    f_req0 = 1'b0;
    f_req1 = 1'b0;
    #1;
    chk("reset_rr", {a_state, a_mwe, a_maddr, a_mdata, a_msize, a_grant, a_ack0, a_ack1, a_d0, a_d1},
        {ST_IDLE, 1'b1, 16'h0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0});
    chk("reset_fx", {f_state, f_mwe, f_maddr, f_mdata, f_msize, f_grant, f_ack0, f_ack1, f_d0, f_d1},
        {ST_IDLE, 1'b1, 16'h0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0});
    repeat (2) @(negedge clk);
  endtask

  task automatic drive(int p, bit we_n, logic [15:0] addr, logic [31:0] d, logic [1:0] sz,
                       logic [W-1:0] e);
    int n = 0;
    p_we[p]    = we_n;
    p_addr[p]  = addr;
    p_wdata[p] = d;
    p_size[p]  = sz;
    p_req[p]   = 1'b1;
    exp_q[p].push_back(e);
    do begin
      @(negedge clk);
      n++;
    end while (!ack_v[p] && n < 40);
    chk($sformatf("ack_timeout_p%0d", p), ack_v[p], 1'b1);
    p_req[p] = 1'b0;
  endtask

  task automatic rand_port(int p);
    int gap;
    bit w;
    for (int k = 0; k < 12; k++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      w = 1'($urandom_range(0, 1));
      drive(p, w, 16'h0100 + 16'($urandom_range(0, 255)), $urandom, 2'($urandom_range(0, 3)),
            mk(0, 0, w, 0, 32'h0));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      p_req[i] = 1'b0; p_addr[i] = 16'h0; p_wdata[i] = 32'h0; p_size[i] = 2'b00; p_we[i] = 1'b1;
    end
    f_req0 = 1'b0;
    f_req1 = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    apply_reset();

    // Word write on p1, then word read back on p0.
    rst_n = 1'b1;
    drive(1, 1'b0, 16'h0010, 32'hDEADBEEF, 2'b11, mk(1, 2, 0, 0, 32'h0));
    drive(0, 1'b1, 16'h0010, 32'h0, 2'b11, mk(1, 5, 1, 1, 32'hDEADBEEF));

    // Byte write into the top lane, then word / halfword / byte reads.
    @(negedge clk);
    apply_reset();
    rst_n = 1'b1;
    drive(1, 1'b0, 16'h0013, 32'h000000AB, 2'b00, mk(1, 2, 0, 0, 32'h0));
    drive(0, 1'b1, 16'h0010, 32'h0, 2'b11, mk(1, 5, 1, 1, 32'hABADBEEF));
    drive(0, 1'b1, 16'h0012, 32'h0, 2'b01, mk(1, 8, 1, 1, 32'h0000ABAD));
    drive(1, 1'b1, 16'h0012, 32'h0, 2'b10, mk(1, 11, 1, 1, 32'h0000ABAD));
    drive(0, 1'b1, 16'h0013, 32'h0, 2'b00, mk(1, 14, 1, 1, 32'h000000AB));

    // Both ports held high from reset: alternation on rr, port 0 monopoly on fixed.
    @(negedge clk);
    apply_reset();
    p_we[0] = 1'b1; p_addr[0] = 16'h0010; p_size[0] = 2'b11;
    p_we[1] = 1'b1; p_addr[1] = 16'h0012; p_size[1] = 2'b01;
    p_req[0] = 1'b1;
    p_req[1] = 1'b1;
    exp_q[0].push_back(mk(1, 2, 1, 1, 32'hABADBEEF));
    exp_q[0].push_back(mk(1, 8, 1, 1, 32'hABADBEEF));
    exp_q[1].push_back(mk(1, 5, 1, 1, 32'h0000ABAD));
    exp_q[1].push_back(mk(1, 11, 1, 1, 32'h0000ABAD));
    f_req0 = 1'b1;
    f_req1 = 1'b1;
    for (int k = 0; k < 4; k++) exp_q[2].push_back(mk(1, 2 + 3 * k, 1, 1, 32'hF00D0100));
    exp_q[3].push_back(mk(1, 14, 1, 1, 32'hF00D0200));
    rst_n = 1'b1;
    repeat (11) @(negedge clk);
    p_req[0] = 1'b0;
    p_req[1] = 1'b0;
    f_req0 = 1'b0;
    repeat (3) @(negedge clk);
    f_req1 = 1'b0;

    // Reset during the ACCESS of a write: nothing committed, no ack.
    @(negedge clk);
    apply_reset();
    rst_n = 1'b1;
    drive(1, 1'b0, 16'h0020, 32'hCAFEF00D, 2'b11, mk(1, 2, 0, 0, 32'h0));
    p_we[1] = 1'b0; p_addr[1] = 16'h0020; p_wdata[1] = 32'h12345678; p_size[1] = 2'b11;
    p_req[1] = 1'b1;
    repeat (2) @(negedge clk);
    chk("access_write_we", {a_state, a_mwe}, {ST_ACCESS, 1'b0});
    apply_reset();
    rst_n = 1'b1;
    drive(0, 1'b1, 16'h0020, 32'h0, 2'b11, mk(1, 2, 1, 1, 32'hCAFEF00D));

    // Randomised contention on the rr instance.
    @(negedge clk);
    apply_reset();
    rst_n = 1'b1;
    fork
      rand_port(0);
      rand_port(1);
    join
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++) chk($sformatf("queue_drained_%0d", i), exp_q[i].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end

endmodule
